// File: rtl/stroke_phase_detector.sv
// Flywheel tick interval measurement and drive/recovery phase classification.
// Optional tick lockout after an accepted tick is enabled by defining STROKE_LOCKOUT_EN.
module stroke_phase_detector #(
    parameter int PW      = 24,
    parameter int CONFIRM = 3,
    parameter int MARGIN  = 4,
    parameter int MIN_GAP = 50,
    parameter int TIMEOUT = 12_500_000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sensor_in,
    output logic          start_drive,
    output logic          start_recovery,
    output logic [1:0]    phase,
    output logic [PW-1:0] tick_period,
    output logic          tick_strobe,
    output logic [15:0]   stroke_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DRIVE    = 2'b01,
        RECOVERY = 2'b10
    } phase_t;

    localparam int RUN_W = $clog2(CONFIRM + 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(CONFIRM);
    localparam logic [PW-1:0]    TIMEOUT_C = PW'(TIMEOUT);
    localparam logic [PW-1:0]    GAP_C     = PW'(MIN_GAP);
    localparam logic [PW:0]      MARGIN_C  = (PW+1)'(MARGIN);
`ifdef STROKE_LOCKOUT_EN
    localparam logic LOCKOUT_ON = 1'b1;
`else
    localparam logic LOCKOUT_ON = 1'b0;
`endif

    function automatic logic [PW-1:0] sat_cnt(input logic [PW-1:0] v);
        return (v == '1) ? v : v + PW'(1);
    endfunction

    function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] v);
        return (v >= RUN_MAX) ? RUN_MAX : v + RUN_W'(1);
    endfunction

    logic          sync_p0, sync_p1, sync_p2;
    logic [PW-1:0] cnt, cnt_d;
    logic [PW-1:0] prev_period, prev_d;
    logic          prev_valid, prev_valid_d;
    logic          seen_first, seen_d;
    logic [RUN_W-1:0] acc_run, acc_d, dec_run, dec_d;
    phase_t        state_q, state_d;
    logic [PW-1:0] period_d;
    logic          strobe_d, drive_d, rec_d;
    logic [15:0]   count_d;

    logic cand, tick, timeout_hit, accel, decel;
    logic [PW:0] n_ext, v_ext;

    assign cand        = sync_p1 & ~sync_p2;
    // Lockout never applies before the first tick of a session.
    assign tick        = cand & ~(LOCKOUT_ON & seen_first & (cnt < GAP_C));
    assign timeout_hit = (cnt == TIMEOUT_C);
    assign n_ext       = {1'b0, cnt};
    assign v_ext       = {1'b0, prev_period};
    assign accel       = (n_ext + MARGIN_C) < v_ext;
    assign decel       = n_ext > (v_ext + MARGIN_C);
    assign phase       = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = sat_cnt(cnt);
        prev_d       = prev_period;
        prev_valid_d = prev_valid;
        seen_d       = seen_first;
        acc_d        = acc_run;
        dec_d        = dec_run;
        period_d     = tick_period;
        strobe_d     = 1'b0;
        drive_d      = 1'b0;
        rec_d        = 1'b0;
        count_d      = stroke_count;

        if (tick) begin
            strobe_d = 1'b1;
            cnt_d    = PW'(1);
            if (!seen_first || timeout_hit) begin
                // Session start; a tick landing on the timeout cycle also restarts.
                seen_d       = 1'b1;
                prev_valid_d = 1'b0;
                acc_d        = '0;
                dec_d        = '0;
                state_d      = IDLE;
                if (timeout_hit) period_d = '0;
            end else if (!prev_valid) begin
                prev_d       = cnt;
                prev_valid_d = 1'b1;
                period_d     = cnt;
            end else begin
                prev_d   = cnt;
                period_d = cnt;
                if (accel) begin
                    acc_d = sat_run(acc_run);
                    dec_d = '0;
                end else if (decel) begin
                    dec_d = sat_run(dec_run);
                    acc_d = '0;
                end
                if (acc_d == RUN_MAX && state_q != DRIVE) begin
                    state_d = DRIVE;
                    drive_d = 1'b1;
                    count_d = stroke_count + 16'd1;
                    acc_d   = '0;
                    dec_d   = '0;
                end else if (dec_d == RUN_MAX && state_q == DRIVE) begin
                    state_d = RECOVERY;
                    rec_d   = 1'b1;
                    acc_d   = '0;
                    dec_d   = '0;
                end
            end
        end else if (timeout_hit) begin
            state_d      = IDLE;
            period_d     = '0;
            acc_d        = '0;
            dec_d        = '0;
            prev_valid_d = 1'b0;
            seen_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0        <= 1'b0;
            sync_p1        <= 1'b0;
            sync_p2        <= 1'b0;
            cnt            <= '0;
            prev_period    <= '0;
            prev_valid     <= 1'b0;
            seen_first     <= 1'b0;
            acc_run        <= '0;
            dec_run        <= '0;
            state_q        <= IDLE;
            tick_period    <= '0;
            tick_strobe    <= 1'b0;
            start_drive    <= 1'b0;
            start_recovery <= 1'b0;
            stroke_count   <= '0;
        end else begin
            sync_p0        <= sensor_in;
            sync_p1        <= sync_p0;
            sync_p2        <= sync_p1;
            cnt            <= cnt_d;
            prev_period    <= prev_d;
            prev_valid     <= prev_valid_d;
            seen_first     <= seen_d;
            acc_run        <= acc_d;
            dec_run        <= dec_d;
            state_q        <= state_d;
            tick_period    <= period_d;
            tick_strobe    <= strobe_d;
            start_drive    <= drive_d;
            start_recovery <= rec_d;
            stroke_count   <= count_d;
        end
    end

endmodule
